// File: rtl/bcd_lcd_writer.sv
// Writes a three-digit BCD value as ASCII to an HD44780 LCD over a 4-bit bus.
// It sends a Set-DDRAM-Address command followed by the hundreds, tens and ones characters.
module bcd_lcd_writer #(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EHIGH   = 12,
  parameter int unsigned T_HOLD    = 1,
  parameter int unsigned T_NIBGAP  = 50,
  parameter int unsigned T_BYTEGAP = 2000,
  parameter bit          BLANK_LZ  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [1:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [3:0] lcd_db,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] LD_SETUP   = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] LD_EHIGH   = TW'(T_EHIGH - 1);
  localparam logic [TW-1:0] LD_HOLD    = TW'(T_HOLD - 1);
  localparam logic [TW-1:0] LD_NIBGAP  = TW'(T_NIBGAP - 1);
  localparam logic [TW-1:0] LD_BYTEGAP = TW'(T_BYTEGAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, GAP} state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [1:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } req_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      byte_q, byte_d;
  logic            lo_q, lo_d;
  req_t            req_q, req_d;
  logic [3:0]      db_d;
  logic            e_d, rs_d, busy_d, done_d;
  logic            active_d;
  logic [7:0]      char_d;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
  endfunction

  // Character for byte slot idx; hundreds/tens blank to a space on leading zeros.
  function automatic logic [7:0] byte_of(input req_t r, input logic [1:0] idx);
    logic [7:0] c;
    c = 8'h00;
    unique case (idx)
      2'd0: c = {1'b1, r.addr};
      2'd1: c = (BLANK_LZ && (r.hundreds == 2'd0)) ? 8'h20
                                                  : digit_char({2'b00, r.hundreds});
      2'd2: c = (BLANK_LZ && (r.hundreds == 2'd0) && (r.tens == 4'd0)) ? 8'h20
                                                                       : digit_char(r.tens);
      2'd3: c = digit_char(r.ones);
    endcase
    return c;
  endfunction

  // Next-state, phase timer and byte/nibble sequencing.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    byte_d  = byte_q;
    lo_d    = lo_q;
    req_d   = req_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          req_d   = '{addr: addr, hundreds: hundreds, tens: tens, ones: ones};
          byte_d  = 2'd0;
          lo_d    = 1'b0;
          state_d = SETUP;
          timer_d = LD_SETUP;
        end
      end
      SETUP: begin
        if (timer_q == '0) begin
          state_d = PULSE;
          timer_d = LD_EHIGH;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      PULSE: begin
        if (timer_q == '0) begin
          state_d = HOLD;
          timer_d = LD_HOLD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      HOLD: begin
        if (timer_q == '0) begin
          state_d = GAP;
          timer_d = lo_q ? LD_BYTEGAP : LD_NIBGAP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (!lo_q) begin
          lo_d    = 1'b1;
          state_d = SETUP;
          timer_d = LD_SETUP;
        end else if (byte_q == 2'd3) begin
          lo_d    = 1'b0;
          byte_d  = 2'd0;
          state_d = IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end else begin
          lo_d    = 1'b0;
          byte_d  = byte_q + 2'd1;
          state_d = SETUP;
          timer_d = LD_SETUP;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Bus outputs are derived from the next state so they can be registered.
    active_d = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
    char_d   = byte_of(req_d, byte_d);
    db_d     = active_d ? (lo_d ? char_d[3:0] : char_d[7:4]) : 4'h0;
    rs_d     = active_d && (byte_d != 2'd0);
    e_d      = (state_d == PULSE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      byte_q  <= 2'd0;
      lo_q    <= 1'b0;
      req_q   <= '0;
      lcd_db  <= 4'h0;
      lcd_e   <= 1'b0;
      lcd_rs  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      byte_q  <= byte_d;
      lo_q    <= lo_d;
      req_q   <= req_d;
      lcd_db  <= db_d;
      lcd_e   <= e_d;
      lcd_rs  <= rs_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_bcd_lcd_writer.sv
// Directed bench for bcd_lcd_writer: small-timing instances with and without blanking,
// plus a default-timing instance for the real strobe spacing.
module tb_bcd_lcd_writer;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b, start_c;
  logic [6:0] addr;
  logic [1:0] hundreds;
  logic [3:0] tens, ones;

  logic [3:0] db_a, db_b, db_c;
  logic       e_a, e_b, e_c, rs_a, rs_b, rs_c, rw_a, rw_b, rw_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;

  bcd_lcd_writer #(.T_SETUP(1), .T_EHIGH(2), .T_HOLD(1), .T_NIBGAP(3), .T_BYTEGAP(5),
                   .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .addr(addr), .hundreds(hundreds),
    .tens(tens), .ones(ones), .lcd_db(db_a), .lcd_e(e_a), .lcd_rs(rs_a),
    .lcd_rw(rw_a), .busy(busy_a), .done(done_a));

  bcd_lcd_writer #(.T_SETUP(1), .T_EHIGH(2), .T_HOLD(1), .T_NIBGAP(3), .T_BYTEGAP(5),
                   .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .addr(addr), .hundreds(hundreds),
    .tens(tens), .ones(ones), .lcd_db(db_b), .lcd_e(e_b), .lcd_rs(rs_b),
    .lcd_rw(rw_b), .busy(busy_b), .done(done_b));

  bcd_lcd_writer dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .addr(addr), .hundreds(hundreds),
    .tens(tens), .ones(ones), .lcd_db(db_c), .lcd_e(e_c), .lcd_rs(rs_c),
    .lcd_rw(rw_c), .busy(busy_c), .done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         sel;
  logic [3:0] m_db;
  logic       m_e, m_rs, m_rw, m_busy, m_done;

  always_comb begin
    m_db = db_a; m_e = e_a; m_rs = rs_a; m_rw = rw_a; m_busy = busy_a; m_done = done_a;
    case (sel)
      1: begin m_db = db_b; m_e = e_b; m_rs = rs_b; m_rw = rw_b; m_busy = busy_b; m_done = done_b; end
      2: begin m_db = db_c; m_e = e_c; m_rs = rs_c; m_rw = rw_c; m_busy = busy_c; m_done = done_c; end
      default: ;
    endcase
  end

  int n_assert = 0;
  int n_fail   = 0;

  int         nstrobe, done_n, done_cnt;
  logic [3:0] nib [8];
  logic [7:0] rs_bits;
  int         rise [8];
  int         wid  [8];
  logic [3:0] gap_db;
  logic       gap_rs;
  logic       busy_at_done;
  logic [3:0] acc_db;
  logic       acc_busy, acc_rs, acc_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Pulse START for one edge and sample the first cycle after acceptance.
  task automatic accept(input int s);
    sel = s;
    @(posedge clk); #1;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    acc_db = m_db; acc_busy = m_busy; acc_rs = m_rs; acc_e = m_e;
  endtask

  // Watch up to max_n cycles after acceptance, recording strobes and DONE.
  task automatic capture(input int s, input int max_n, input int poke_at, input bit b2b,
                         input int gap_at);
    logic prev_e;
    sel = s;
    nstrobe = 0; done_n = -1; done_cnt = 0; rs_bits = '0; prev_e = 1'b0;
    gap_db = 4'hx; gap_rs = 1'bx; busy_at_done = 1'bx;
    for (int k = 0; k < 8; k++) begin nib[k] = 4'hx; rise[k] = -1; wid[k] = 0; end
    for (int n = 1; n <= max_n; n++) begin
      @(posedge clk); #1;
      if (n == poke_at) begin
        addr = 7'h7F; hundreds = 2'd3; tens = 4'd9; ones = 4'd9;
        set_start(s, 1'b1);
      end
      if (n == poke_at + 1) set_start(s, 1'b0);
      if (m_e && !prev_e) begin
        if (nstrobe < 8) begin
          nib[nstrobe] = m_db; rs_bits[nstrobe] = m_rs; rise[nstrobe] = n;
        end
        nstrobe++;
      end
      if (m_e && nstrobe >= 1 && nstrobe <= 8) wid[nstrobe-1]++;
      prev_e = m_e;
      if (n == gap_at) begin gap_db = m_db; gap_rs = m_rs; end
      if (m_done) begin
        done_cnt++;
        if (done_n < 0) begin done_n = n; busy_at_done = m_busy; end
        if (b2b) begin
          set_start(s, 1'b1);
          break;
        end
      end
    end
  endtask

  task automatic check_txn(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int exp_done,
                           input int exp_w, input int exp_nsp, input int exp_bsp);
    chk({tag, "_strobes"}, nstrobe, 8);
    chk({tag, "_byte0"}, {nib[0], nib[1]}, b0);
    chk({tag, "_byte1"}, {nib[2], nib[3]}, b1);
    chk({tag, "_byte2"}, {nib[4], nib[5]}, b2);
    chk({tag, "_byte3"}, {nib[6], nib[7]}, b3);
    chk({tag, "_rs"}, rs_bits, 8'hFC);
    chk({tag, "_done_cycle"}, done_n, exp_done);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 1'b0);
    chk({tag, "_e_width_first"}, wid[0], exp_w);
    chk({tag, "_e_width_last"}, wid[7], exp_w);
    chk({tag, "_nibble_spacing"}, rise[1] - rise[0], exp_nsp);
    chk({tag, "_byte_spacing"}, rise[2] - rise[1], exp_bsp);
    chk({tag, "_gap_bus"}, {gap_db, gap_rs}, 5'h00);
  endtask

  initial begin
    int e_seen;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    addr = '0; hundreds = '0; tens = '0; ones = '0; sel = 0;
    #1;
    chk("reset_outputs", {db_a, e_a, rs_a, busy_a, done_a}, 8'h00);
    chk("reset_rw", rw_a, 1'b0);
    #20 rst_n = 1'b1;

    // 255 at the second-line address
    addr = 7'h40; hundreds = 2'd2; tens = 4'd5; ones = 4'd5;
    accept(0);
    chk("w255_acc_busy", acc_busy, 1'b1);
    chk("w255_acc_db", acc_db, 4'hC);
    chk("w255_acc_rs_e", {acc_rs, acc_e}, 2'b00);
    capture(0, 70, 0, 1'b0, 5);
    check_txn("w255", 8'hC0, 8'h32, 8'h35, 8'h35, 64, 2, 7, 9);

    // Leading-zero blanking
    addr = 7'h05; hundreds = 2'd0; tens = 4'd0; ones = 4'd7;
    accept(0); capture(0, 70, 0, 1'b0, 5);
    check_txn("blank007", 8'h85, 8'h20, 8'h20, 8'h37, 64, 2, 7, 9);

    hundreds = 2'd0; tens = 4'd4; ones = 4'd2;
    accept(0); capture(0, 70, 0, 1'b0, 5);
    check_txn("blank042", 8'h85, 8'h20, 8'h34, 8'h32, 64, 2, 7, 9);

    // Out-of-range BCD digits
    hundreds = 2'd1; tens = 4'hC; ones = 4'hA;
    accept(0); capture(0, 70, 0, 1'b0, 5);
    check_txn("invalid", 8'h85, 8'h31, 8'h3F, 8'h3F, 64, 2, 7, 9);

    // Blanking disabled
    hundreds = 2'd0; tens = 4'd0; ones = 4'd7;
    accept(1); capture(1, 70, 0, 1'b0, 5);
    check_txn("noblank", 8'h85, 8'h30, 8'h30, 8'h37, 64, 2, 7, 9);

    // START while busy is ignored; START on the DONE cycle is accepted
    addr = 7'h00; hundreds = 2'd1; tens = 4'd2; ones = 4'd3;
    accept(0); capture(0, 70, 20, 1'b1, 5);
    check_txn("ignore", 8'h80, 8'h31, 8'h32, 8'h33, 64, 2, 7, 9);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    chk("b2b_busy", m_busy, 1'b1);
    chk("b2b_db", m_db, 4'hF);
    chk("b2b_done_low", m_done, 1'b0);
    capture(0, 70, 0, 1'b0, 5);
    check_txn("b2b", 8'hFF, 8'h33, 8'h39, 8'h39, 64, 2, 7, 9);

    // Reset during an E pulse
    addr = 7'h00; hundreds = 2'd1; tens = 4'd2; ones = 4'd3;
    accept(0);
    @(posedge clk); #1;
    chk("rst_pulse_e_high", m_e, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_e", m_e, 1'b0);
    chk("rst_async_outputs", {m_db, m_rs, m_rw, m_busy, m_done}, 8'h00);
    @(posedge clk); #2 rst_n = 1'b1;
    e_seen = 0; done_cnt = 0;
    for (int n = 0; n < 70; n++) begin
      @(posedge clk); #1;
      if (m_done) done_cnt++;
      if (m_e) e_seen++;
    end
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_strobe", e_seen, 0);
    accept(0); capture(0, 70, 0, 1'b0, 5);
    check_txn("post_rst", 8'h80, 8'h31, 8'h32, 8'h33, 64, 2, 7, 9);

    // Default timing
    addr = 7'h00; hundreds = 2'd1; tens = 4'd2; ones = 4'd8;
    accept(2);
    chk("dflt_acc_busy", acc_busy, 1'b1);
    capture(2, 8400, 0, 1'b0, 20);
    check_txn("dflt", 8'h80, 8'h31, 8'h32, 8'h38, 8320, 12, 65, 2015);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_lcd_writer.md
Name: bcd_lcd_writer

Overview:
- Downstream consumer of the 8-bit-to-BCD converter: takes HUNDREDS/TENS/ONES digits and writes them as three ASCII characters to the Spartan-3E character LCD (HD44780-compatible, 4-bit bus, already initialised elsewhere).
- Per request, sends one Set-DDRAM-Address command and then three data bytes. Each byte goes out as two nibbles with programmable E-strobe timing.
- Reports BUSY while writing and pulses DONE on completion.

Parameters:
T_SETUP, 2, cycles DB/RS stable before E rises (>=1)
T_EHIGH, 12, cycles E held high (>=1)
T_HOLD, 1, cycles DB/RS held after E falls (>=1)
T_NIBGAP, 50, idle cycles between high and low nibble of a byte (>=1)
T_BYTEGAP, 2000, idle cycles after low nibble before next byte or completion (>=1)
BLANK_LZ, 1, 1 = leading-zero blanking (space 0x20), 0 = always print three digits

Ports:
CLK  in  1  system clock (50 MHz)
RST_N  in  1  asynchronous active-low reset
START  in  1  request pulse; accepted only in IDLE
ADDR  in  7  DDRAM address of the hundreds character
HUNDREDS  in  2  BCD hundreds digit
TENS  in  4  BCD tens digit
ONES  in  4  BCD ones digit
LCD_DB  out  4  LCD data nibble (SF_D[11:8])
LCD_E  out  1  LCD enable strobe
LCD_RS  out  1  0 = command, 1 = data
LCD_RW  out  1  tied 0 (write only)
BUSY  out  1  high from the cycle after acceptance until completion
DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0 (LCD_DB=0, LCD_E=0, LCD_RS=0, LCD_RW=0, BUSY=0, DONE=0). State IDLE. All counters 0.
- Reset asserted mid-operation: transaction aborts immediately, LCD_E drops asynchronously, no DONE pulse.
- Acceptance: on a rising edge with state IDLE and START=1, latch ADDR and all digits. BUSY=1 from the next cycle.
  - START while BUSY is ignored. Latched values are not affected by input changes during a write.
- Byte sequence (index 0..3):
  - b0 = {1'b1, ADDR}, RS=0.
  - b1 = hundreds char, RS=1.
  - b2 = tens char, RS=1.
  - b3 = ones char, RS=1.
- Character encoding: digit d (0..9) -> 0x30+d. Digit >9 (TENS/ONES) -> 0x3F '?'.
- Blanking when BLANK_LZ=1:
  - hundreds char = 0x20 if HUNDREDS=0.
  - tens char = 0x20 if HUNDREDS=0 and TENS=0.
  - ones char is never blanked.
- FSM states: IDLE, SETUP, PULSE, HOLD, GAP. Each nibble goes SETUP(T_SETUP) -> PULSE(T_EHIGH, LCD_E=1) -> HOLD(T_HOLD) -> GAP.
  - GAP length is T_NIBGAP after a high nibble and T_BYTEGAP after a low nibble.
  - High nibble b[7:4] is sent first, then b[3:0].
- LCD_DB and LCD_RS are stable from the first SETUP cycle through the last HOLD cycle.
- LCD_E is 1 only in PULSE. It is registered and glitch-free.
- In GAP and IDLE, LCD_DB=0 and LCD_RS=0.
- After the GAP of byte 3's low nibble, the FSM enters IDLE. In that cycle DONE=1 and BUSY=0.
  - START in that same cycle is accepted (back-to-back writes allowed).
- Timer: 16-bit down-counter reloaded per phase. All T_* must be < 65536.
- Total duration, acceptance edge to DONE: 4*(2*(T_SETUP+T_EHIGH+T_HOLD)+T_NIBGAP+T_BYTEGAP) cycles.
  - Defaults: 8320 cycles.

Test Plan (small timing: T_SETUP=1, T_EHIGH=2, T_HOLD=1, T_NIBGAP=3, T_BYTEGAP=5 -> 64 cycles/transaction):
- Write 255: ADDR=0x40, H=2, T=5, O=5, START pulse -> E strobes capture nibbles C,0 (RS=0), then 3,2 / 3,5 / 3,5 (RS=1). DONE exactly 64 cycles after acceptance. E high exactly 2 cycles per strobe.
- Blanking, BLANK_LZ=1: H=0, T=0, O=7 -> data bytes 0x20, 0x20, 0x37. With H=0, T=4, O=2 -> 0x20, 0x34, 0x32. With BLANK_LZ=0 and H=0, T=0, O=7 -> 0x30, 0x30, 0x37.
- Invalid digit: T=0xC, O=0xA, H=1 -> bytes 0x31, 0x3F, 0x3F.
- START ignored while BUSY: change digits and pulse START at cycle 20 -> still 8 strobes with the original data, one DONE. Second START on the DONE cycle -> new transaction begins; BUSY back to 1 the next cycle.
- Reset mid-write: assert RST_N=0 during a PULSE phase -> LCD_E=0 immediately, all outputs 0, no DONE. After release, a fresh START completes normally.
- Default parameters: one transaction -> DONE at cycle 8320. Measured E-high width 12 cycles, nibble-to-nibble E-rise spacing 65 cycles, byte-to-byte E-rise spacing 2015 cycles.
